// File: rtl/lv_wdg_scan_pkg.sv
// Shared types, CRC constants and the bit-serial CRC-8 helper for the watchdog
// register scan and the register file write path.
package lv_wdg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CHK
  } scan_state_e;

  localparam logic [7:0]  LV_CRC8_POLY     = 8'h07;
  localparam logic [7:0]  LV_CRC8_INIT     = 8'hFF;
  localparam int unsigned LV_CRC8_MAX_BITS = 64;

  // Data is left-aligned: only the top nbits are consumed, MSB first.
  function automatic logic [7:0] lv_crc8(
    input logic [LV_CRC8_MAX_BITS-1:0] data,
    input int unsigned                 nbits
  );
    logic [7:0] crc;
    logic       fb;
    logic [5:0] idx;
    crc = LV_CRC8_INIT;
    for (int unsigned i = 0; i < LV_CRC8_MAX_BITS; i++) begin
      if (i < nbits) begin
        idx = 6'(LV_CRC8_MAX_BITS - 1 - i);
        fb  = crc[7] ^ data[idx];
        crc = {crc[6:0], 1'b0} ^ (fb ? LV_CRC8_POLY : 8'h00);
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/lv_crc8_calc.sv
// Combinational CRC-8 (poly 0x07, init 0xFF, MSB first, no final XOR) over a
// DW-bit word.
module lv_crc8_calc
  import lv_wdg_scan_pkg::*;
#(
  parameter int unsigned DW = 15
) (
  input  logic [DW-1:0] i_data,
  output logic [7:0]    o_crc
);

  logic [LV_CRC8_MAX_BITS-1:0] data_al;

  always_comb begin
    data_al = LV_CRC8_MAX_BITS'(i_data) << (LV_CRC8_MAX_BITS - DW);
    o_crc   = lv_crc8(data_al, DW);
  end

endmodule

// File: rtl/lv_wdg_reg_scan.sv
// Watchdog register-scan engine: periodically reads an address window through
// the arbiter scan port and checks each word against its stored CRC.
module lv_wdg_reg_scan
  import lv_wdg_scan_pkg::*;
#(
  parameter int unsigned       REG_AW          = 7,
  parameter int unsigned       REG_DW          = 8,
  parameter int unsigned       REG_CRC_W       = 8,
  parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h1F,
  parameter int unsigned       SCAN_PERIOD     = 1000,
  parameter int unsigned       ACK_TIMEOUT     = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_scan_en,
  input  logic                 i_spi_rst_wdg,
  input  logic                 i_err_clr,
  output logic                 o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
  input  logic                 i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
  output logic                 o_scan_crc_err,
  output logic                 o_scan_timeout,
  output logic                 o_scan_err_sticky,
  output logic [REG_AW-1:0]    o_scan_err_addr,
  output logic                 o_scan_done
);

  localparam int unsigned PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  scan_state_e          state;
  logic [PER_W-1:0]     per_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [REG_DW-1:0]    data_q;
  logic [REG_CRC_W-1:0] crc_q;
  logic                 tmo_hit;
  logic [7:0]           crc_calc;
  logic [REG_CRC_W-1:0] crc_exp;

  lv_crc8_calc #(
    .DW (REG_AW + REG_DW)
  ) u_crc8 (
    .i_data ({o_wdg_scan_rac_addr, data_q}),
    .o_crc  (crc_calc)
  );

  always_comb begin
    crc_exp = REG_CRC_W'(crc_calc);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                 <= IDLE;
      per_cnt               <= '0;
      tmo_cnt               <= '0;
      data_q                <= '0;
      crc_q                 <= '0;
      tmo_hit               <= 1'b0;
      o_wdg_scan_rac_rd_req <= 1'b0;
      o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
      o_scan_crc_err        <= 1'b0;
      o_scan_timeout        <= 1'b0;
      o_scan_err_sticky     <= 1'b0;
      o_scan_err_addr       <= '0;
      o_scan_done           <= 1'b0;
    end else begin
      o_scan_crc_err <= 1'b0;
      o_scan_timeout <= 1'b0;
      o_scan_done    <= 1'b0;

      // A same-cycle error record below overrides this clear.
      if (i_err_clr) begin
        o_scan_err_sticky <= 1'b0;
        o_scan_err_addr   <= '0;
      end

      if (!i_scan_en) begin
        state                 <= IDLE;
        per_cnt               <= '0;
        tmo_cnt               <= '0;
        tmo_hit               <= 1'b0;
        o_wdg_scan_rac_rd_req <= 1'b0;
        o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_spi_rst_wdg) begin
              per_cnt <= '0;
            end else if (per_cnt == PER_LAST) begin
              per_cnt               <= '0;
              tmo_cnt               <= '0;
              state                 <= REQ;
              o_wdg_scan_rac_rd_req <= 1'b1;
              o_wdg_scan_rac_addr   <= SCAN_START_ADDR;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end

          REQ: begin
            if (i_rac_wdg_scan_ack) begin
              data_q                <= i_rac_wdg_scan_data;
              crc_q                 <= i_rac_wdg_scan_crc;
              tmo_hit               <= 1'b0;
              o_wdg_scan_rac_rd_req <= 1'b0;
              state                 <= CHK;
            end else if (tmo_cnt == TMO_LAST) begin
              // Timeout passes through CHK with the compare suppressed so the
              // advance and the one-cycle request gap match the ack path.
              tmo_hit               <= 1'b1;
              o_wdg_scan_rac_rd_req <= 1'b0;
              o_scan_timeout        <= 1'b1;
              o_scan_err_sticky     <= 1'b1;
              if (!o_scan_err_sticky || i_err_clr) begin
                o_scan_err_addr <= o_wdg_scan_rac_addr;
              end
              state <= CHK;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          CHK: begin
            if (!tmo_hit && (crc_q != crc_exp)) begin
              o_scan_crc_err    <= 1'b1;
              o_scan_err_sticky <= 1'b1;
              if (!o_scan_err_sticky || i_err_clr) begin
                o_scan_err_addr <= o_wdg_scan_rac_addr;
              end
            end
            tmo_hit <= 1'b0;
            tmo_cnt <= '0;
            if (o_wdg_scan_rac_addr == SCAN_END_ADDR) begin
              o_scan_done         <= 1'b1;
              per_cnt             <= '0;
              o_wdg_scan_rac_addr <= SCAN_START_ADDR;
              state               <= IDLE;
            end else begin
              o_wdg_scan_rac_addr   <= o_wdg_scan_rac_addr + 1'b1;
              o_wdg_scan_rac_rd_req <= 1'b1;
              state                 <= REQ;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lv_wdg_reg_scan.sv
// Directed bench for lv_wdg_reg_scan: scoreboarded ack responder plus checks of
// period timing, CRC errors, timeout, kick, abort, reset and error clear.
module tb_lv_wdg_reg_scan;

  localparam logic [6:0]  S_ADDR = 7'h06;
  localparam logic [6:0]  E_ADDR = 7'h08;
  localparam int unsigned PERIOD = 10;
  localparam int unsigned TMO    = 4;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       scan_en = 1'b0;
  logic       kick    = 1'b0;
  logic       err_clr = 1'b0;
  logic       ack     = 1'b0;
  logic [7:0] rdata   = '0;
  logic [7:0] rcrc    = '0;
  logic       rd_req, crc_err, tmo_p, sticky, done;
  logic [6:0] addr, err_addr;

  typedef struct {
    logic [6:0] addr;
    logic       crc_err;
    logic       done;
    int         cd;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] bad_mask    = '0;
  logic [127:0] no_ack_mask = '0;
  logic [6:0]   nxt_addr    = S_ADDR;
  int           clr_addr    = -1;
  int           req_age     = 0;
  int           n_crc = 0, n_tmo = 0, n_done = 0;
  int           tests = 0, fails = 0;

  lv_wdg_reg_scan #(
    .REG_AW          (7),
    .REG_DW          (8),
    .REG_CRC_W       (8),
    .SCAN_START_ADDR (S_ADDR),
    .SCAN_END_ADDR   (E_ADDR),
    .SCAN_PERIOD     (PERIOD),
    .ACK_TIMEOUT     (TMO)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_scan_en             (scan_en),
    .i_spi_rst_wdg         (kick),
    .i_err_clr             (err_clr),
    .o_wdg_scan_rac_rd_req (rd_req),
    .o_wdg_scan_rac_addr   (addr),
    .i_rac_wdg_scan_ack    (ack),
    .i_rac_wdg_scan_data   (rdata),
    .i_rac_wdg_scan_crc    (rcrc),
    .o_scan_crc_err        (crc_err),
    .o_scan_timeout        (tmo_p),
    .o_scan_err_sticky     (sticky),
    .o_scan_err_addr       (err_addr),
    .o_scan_done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_ref(input logic [6:0] a, input logic [7:0] d);
    logic [14:0] m;
    logic [7:0]  c;
    m = {a, d};
    c = 8'hFF;
    for (int i = 14; i >= 0; i--) begin
      if (c[7] ^ m[i]) c = (c << 1) ^ 8'h07;
      else             c = c << 1;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs, retire scoreboard entries, answer new requests.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    ack     = 1'b0;
    err_clr = 1'b0;
    if (crc_err) n_crc++;
    if (tmo_p)   n_tmo++;
    if (done)    n_done++;
    if (sb.size() > 0) begin
      e = sb[0];
      e.cd--;
      sb[0] = e;
      if (e.cd == 0) begin
        e = sb.pop_front();
        check("sb_crc_err", crc_err, e.crc_err);
        check("sb_done", done, e.done);
      end else if (e.cd == 1 && int'(e.addr) == clr_addr) begin
        err_clr = 1'b1;
      end
    end
    if (rd_req) req_age++;
    else        req_age = 0;
    if (rd_req && req_age == 1) begin
      check("req_addr", addr, nxt_addr);
      nxt_addr = (nxt_addr == E_ADDR) ? S_ADDR : nxt_addr + 7'd1;
    end
    if (rd_req && req_age == 2 && !no_ack_mask[addr]) begin
      rdata     = 8'($urandom);
      rcrc      = crc_ref(addr, rdata) ^ (bad_mask[addr] ? 8'h01 : 8'h00);
      ack       = 1'b1;
      e.addr    = addr;
      e.crc_err = bad_mask[addr];
      e.done    = (addr == E_ADDR);
      e.cd      = 2;
      sb.push_back(e);
    end
  endtask

  task automatic wait_req(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (rd_req) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_until_done(input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("pass_done", seen, 1'b1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int n, hi, crc0, tmo0, done0;

    // Reset state
    rst     = 1'b1;
    scan_en = 1'b1;
    repeat (3) tick();
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_addr", addr, S_ADDR);
    check("rst_crc_err", crc_err, 1'b0);
    check("rst_timeout", tmo_p, 1'b0);
    check("rst_sticky", sticky, 1'b0);
    check("rst_err_addr", err_addr, 7'h00);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    // Clean pass
    wait_req(30, n);
    check("first_req_delay", n, 10);
    check("first_req_addr", addr, S_ADDR);
    run_until_done(40);
    check("clean_sticky", sticky, 1'b0);
    check("clean_crc_cnt", n_crc, 0);
    check("clean_idle_addr", addr, S_ADDR);
    check("clean_idle_req", rd_req, 1'b0);

    // CRC mismatches at 0x07 and 0x08: first address kept
    bad_mask[7] = 1'b1;
    bad_mask[8] = 1'b1;
    wait_req(30, n);
    check("period_gap", n, 10);
    run_until_done(40);
    check("crc_pulse_cnt", n_crc, 2);
    check("crc_sticky", sticky, 1'b1);
    check("crc_err_addr", err_addr, 7'h07);
    bad_mask = '0;
    err_clr  = 1'b1;
    tick();
    check("clr_sticky", sticky, 1'b0);
    check("clr_err_addr", err_addr, 7'h00);

    // Ack timeout at 0x06
    no_ack_mask[6] = 1'b1;
    wait_req(30, n);
    check("req_after_clr", n, 9);
    hi = 1;
    while (rd_req && hi < 20) begin
      tick();
      if (rd_req) hi++;
    end
    check("tmo_req_cycles", hi, 4);
    check("tmo_pulse", tmo_p, 1'b1);
    check("tmo_sticky", sticky, 1'b1);
    check("tmo_err_addr", err_addr, 7'h06);
    tick();
    check("tmo_pulse_width", tmo_p, 1'b0);
    check("tmo_next_req", rd_req, 1'b1);
    check("tmo_next_addr", addr, 7'h07);
    no_ack_mask = '0;
    run_until_done(40);
    check("tmo_cnt", n_tmo, 1);
    check("tmo_err_addr_kept", err_addr, 7'h06);

    // Watchdog kick at period count 8
    repeat (8) tick();
    kick = 1'b1;
    tick();
    kick = 1'b0;
    wait_req(30, n);
    check("kick_delay", n, 10);
    run_until_done(40);

    // Abort mid-request at 0x07
    no_ack_mask[7] = 1'b1;
    wait_req(30, n);
    for (int i = 0; i < 10 && !(rd_req && addr == 7'h07); i++) tick();
    check("abort_pre_req", rd_req, 1'b1);
    check("abort_pre_addr", addr, 7'h07);
    crc0  = n_crc;
    tmo0  = n_tmo;
    done0 = n_done;
    scan_en = 1'b0;
    tick();
    check("abort_rd_req", rd_req, 1'b0);
    check("abort_addr", addr, S_ADDR);
    check("abort_sticky", sticky, 1'b1);
    check("abort_err_addr", err_addr, 7'h06);
    repeat (6) tick();
    check("abort_no_tmo", n_tmo, tmo0);
    check("abort_no_crc", n_crc, crc0);
    check("abort_no_done", n_done, done0);
    no_ack_mask = '0;
    nxt_addr    = S_ADDR;
    scan_en     = 1'b1;
    wait_req(30, n);
    check("reenable_delay", n, 10);
    run_until_done(40);

    // Reset mid-scan
    wait_req(30, n);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_rd_req", rd_req, 1'b0);
    check("mrst_addr", addr, S_ADDR);
    check("mrst_sticky", sticky, 1'b0);
    check("mrst_err_addr", err_addr, 7'h00);
    sb.delete();
    nxt_addr = S_ADDR;

    // Error clear coincident with a new CRC error at 0x08
    bad_mask[7] = 1'b1;
    bad_mask[8] = 1'b1;
    clr_addr    = 8;
    crc0        = n_crc;
    wait_req(30, n);
    check("mrst_req_delay", n, 10);
    run_until_done(40);
    check("clrset_crc_cnt", n_crc - crc0, 2);
    check("clrset_sticky", sticky, 1'b1);
    check("clrset_err_addr", err_addr, 7'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
